// File: rtl/sha256_padder_if.sv
// Purpose: word-in / block-out stream bundle for the SHA-256 message padder.
// Latency: none, this is only wiring.
// Backpressure: in_valid/in_ready on the word side, blk_valid/blk_ready on the block side.
// Ports: in_valid/in_ready/in_data/in_last/in_nbytes carry message words;
//        blk_valid/blk_ready/blk/blk_first/blk_last carry 512-bit padded blocks.
interface sha256_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [2:0]   in_nbytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk;
  logic         blk_first;
  logic         blk_last;

  // Padder side.
  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, blk_ready,
    output in_ready, blk_valid, blk, blk_first, blk_last
  );

  // Message source / block sink side.
  modport master (
    output in_valid, in_data, in_last, in_nbytes, blk_ready,
    input  in_ready, blk_valid, blk, blk_first, blk_last
  );
endinterface

// File: rtl/sha256_padder.sv
// Purpose: packs 32-bit big-endian message words into 512-bit SHA-256 blocks and applies 0x80 + 64-bit length padding.
// Latency: 1 cycle from the completing word to blk_valid; an extra block follows its predecessor's transfer by 1 cycle.
// Backpressure: words are refused (in_ready=0) while a block is held; the block holds steady until blk_ready.
// Ports: CLK, nreset (synchronous, active-low), bus (slave modport of sha256_padder_if).
module sha256_padder (
  input  logic            CLK,
  input  logic            nreset,
  sha256_padder_if.slave  bus
);

  typedef enum logic [1:0] {ACCEPT, EMIT, EXTRA} state_t;

  state_t       state_q, state_d;
  logic [3:0]   widx_q, widx_d;
  logic [63:0]  bitcnt_q, bitcnt_d;
  logic [511:0] blk_q, blk_d;
  logic         extra_q, extra_d;   // an EXTRA block must follow the current one
  logic         pad_q, pad_d;       // the 0x80 byte still has to go into EXTRA word 0
  logic         first_q, first_d;
  logic         last_q, last_d;

  logic [31:0]  word_mask;
  logic [31:0]  pad_word;
  logic [31:0]  data_word;
  logic         full_word;
  logic [4:0]   pad_pos;
  logic [63:0]  bitcnt_add;

  // Byte masking and in-word terminator for the incoming word.
  always_comb begin
    word_mask = 32'hFFFF_FFFF;
    case (bus.in_nbytes)
      3'd0:    word_mask = 32'h0000_0000;
      3'd1:    word_mask = 32'hFF00_0000;
      3'd2:    word_mask = 32'hFFFF_0000;
      3'd3:    word_mask = 32'hFFFF_FF00;
      default: word_mask = 32'hFFFF_FFFF;
    endcase
  end

  assign full_word  = (bus.in_nbytes >= 3'd4);
  assign pad_word   = (bus.in_last && !full_word) ? (32'h8000_0000 >> {bus.in_nbytes, 3'b000}) : 32'h0;
  assign data_word  = (bus.in_data & word_mask) | pad_word;
  // Word index the 0x80 byte lands in: same word if short, next word if full.
  assign pad_pos    = {1'b0, widx_q} + {4'b0, full_word};
  assign bitcnt_add = bitcnt_q + {58'b0, bus.in_nbytes, 3'b000};

  always_comb begin
    state_d  = state_q;
    widx_d   = widx_q;
    bitcnt_d = bitcnt_q;
    blk_d    = blk_q;
    extra_d  = extra_q;
    pad_d    = pad_q;
    first_d  = first_q;
    last_d   = last_q;

    case (state_q)
      ACCEPT: begin
        if (bus.in_valid) begin
          bitcnt_d = bitcnt_add;
          for (int i = 0; i < 16; i++) begin
            if (widx_q == i[3:0]) blk_d[480-32*i +: 32] = data_word;
          end
          if (!bus.in_last) begin
            if (widx_q == 4'd15) begin
              state_d = EMIT;
              last_d  = 1'b0;
              extra_d = 1'b0;
            end else begin
              widx_d = widx_q + 4'd1;
            end
          end else begin
            state_d = EMIT;
            if (full_word && widx_q != 4'd15) begin
              for (int i = 1; i < 16; i++) begin
                if (widx_q == 4'(i - 1)) blk_d[480-32*i +: 32] = 32'h8000_0000;
              end
            end
            if (pad_pos <= 5'd13) begin
              // Room for the length in words 14-15 of this block.
              blk_d[63:0] = bitcnt_add;
              last_d      = 1'b1;
              extra_d     = 1'b0;
            end else begin
              last_d  = 1'b0;
              extra_d = 1'b1;
              pad_d   = full_word && (widx_q == 4'd15);
            end
          end
        end
      end

      EMIT: begin
        if (bus.blk_ready) begin
          first_d = last_q;
          if (extra_q) begin
            state_d = EXTRA;
            blk_d   = {(pad_q ? 32'h8000_0000 : 32'h0), 416'b0, bitcnt_q};
            last_d  = 1'b1;
            extra_d = 1'b0;
            pad_d   = 1'b0;
          end else begin
            state_d = ACCEPT;
            widx_d  = 4'd0;
            blk_d   = '0;
            last_d  = 1'b0;
            if (last_q) bitcnt_d = '0;
          end
        end
      end

      EXTRA: begin
        if (bus.blk_ready) begin
          state_d  = ACCEPT;
          first_d  = 1'b1;
          widx_d   = 4'd0;
          blk_d    = '0;
          bitcnt_d = '0;
          last_d   = 1'b0;
        end
      end

      default: state_d = ACCEPT;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nreset) begin
      state_q  <= ACCEPT;
      widx_q   <= 4'd0;
      bitcnt_q <= '0;
      blk_q    <= '0;
      extra_q  <= 1'b0;
      pad_q    <= 1'b0;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      widx_q   <= widx_d;
      bitcnt_q <= bitcnt_d;
      blk_q    <= blk_d;
      extra_q  <= extra_d;
      pad_q    <= pad_d;
      first_q  <= first_d;
      last_q   <= last_d;
    end
  end

  assign bus.in_ready  = (state_q == ACCEPT);
  assign bus.blk_valid = (state_q != ACCEPT);
  assign bus.blk       = blk_q;
  assign bus.blk_first = first_q;
  assign bus.blk_last  = last_q;

endmodule

// File: tb/tb_sha256_padder.sv
// Purpose: directed checks of sha256_padder block formatting, flags, stalls and reset.
// Latency: not applicable (testbench).
// Backpressure: the bench drives blk_ready, including a multi-cycle stall.
module tb_sha256_padder;

  logic CLK = 1'b0;
  logic nreset;
  int   checks = 0;
  int   errors = 0;

  logic [511:0] exp_abc;
  logic [511:0] e;

  sha256_padder_if bus();

  sha256_padder dut (
    .CLK    (CLK),
    .nreset (nreset),
    .bus    (bus)
  );

  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sequential byte pattern: word i holds bytes 4i..4i+3.
  function automatic logic [31:0] pw(input int i);
    return {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
  endfunction

  function automatic logic [511:0] put(input logic [511:0] b, input int idx, input logic [31:0] w);
    b[480-32*idx +: 32] = w;
    return b;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic last);
    bit done = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_nbytes = n;
    bus.in_last   = last;
    for (int c = 0; c < 50 && !done; c++) begin
      done = bus.in_ready;
      tick();
    end
    bus.in_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic send_seq(input int nw);
    for (int i = 0; i < nw; i++) send_word(pw(i), 3'd4, 1'b0);
  endtask

  task automatic expect_block(input string tag, input logic [511:0] eb, input logic ef, input logic el);
    bit done = 1'b0;
    logic [511:0] b = '0;
    logic f = 1'b0;
    logic l = 1'b0;
    bus.blk_ready = 1'b1;
    for (int c = 0; c < 50 && !done; c++) begin
      if (bus.blk_valid) begin
        b = bus.blk;
        f = bus.blk_first;
        l = bus.blk_last;
        done = 1'b1;
      end
      tick();
    end
    bus.blk_ready = 1'b0;
    if (!done) chk({tag, "_timeout"}, 0, 1);
    chk({tag, "_blk"}, b, eb);
    chk({tag, "_first"}, f, ef);
    chk({tag, "_last"}, l, el);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.blk_ready = 1'b0;
    nreset        = 1'b0;
    tick();
    tick();
    nreset = 1'b1;

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_blk_valid", bus.blk_valid, 0);
    chk("rst_blk_first", bus.blk_first, 1);
    chk("rst_blk_last", bus.blk_last, 0);

    // "abc": 24-bit message
    exp_abc = put(put('0, 0, 32'h6162_6380), 15, 32'h0000_0018);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    expect_block("abc", exp_abc, 1'b1, 1'b1);

    // 56 bytes: terminator fills word 14, length spills into a second block
    e = '0;
    for (int i = 0; i < 14; i++) e = put(e, i, pw(i));
    e = put(e, 14, 32'h8000_0000);
    send_seq(13);
    send_word(pw(13), 3'd4, 1'b1);
    expect_block("b56_1", e, 1'b1, 1'b0);
    expect_block("b56_2", put('0, 15, 32'h0000_01C0), 1'b0, 1'b1);

    // 64 bytes: terminator and length both go to the extra block
    e = '0;
    for (int i = 0; i < 16; i++) e = put(e, i, pw(i));
    send_seq(15);
    send_word(pw(15), 3'd4, 1'b1);
    expect_block("b64_1", e, 1'b1, 1'b0);
    expect_block("b64_2", put(put('0, 0, 32'h8000_0000), 15, 32'h0000_0200), 1'b0, 1'b1);

    // Empty message; data bits must be ignored
    send_word(32'hDEAD_BEEF, 3'd0, 1'b1);
    expect_block("empty", put('0, 0, 32'h8000_0000), 1'b1, 1'b1);

    // 55 bytes: terminator lands in word 13, length still fits
    e = '0;
    for (int i = 0; i < 13; i++) e = put(e, i, pw(i));
    e = put(e, 13, 32'h3435_3680);
    e = put(e, 15, 32'h0000_01B8);
    send_seq(13);
    send_word(pw(13), 3'd3, 1'b1);
    expect_block("b55", e, 1'b1, 1'b1);

    // 5 bytes: masking of unused bytes in the final word
    e = put(put(put('0, 0, 32'h1122_3344), 1, 32'h5580_0000), 15, 32'h0000_0028);
    send_word(32'h1122_3344, 3'd4, 1'b0);
    send_word(32'h55AA_BBCC, 3'd1, 1'b1);
    expect_block("b5", e, 1'b1, 1'b1);

    // Stall: block held 5 cycles while the next message's word waits
    send_word(32'h6162_6300, 3'd3, 1'b1);
    for (int c = 0; c < 50 && !bus.blk_valid; c++) tick();
    chk("bp_valid0", bus.blk_valid, 1);
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h6400_0000;
    bus.in_nbytes = 3'd1;
    bus.in_last   = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_blk", bus.blk, exp_abc);
      chk("bp_first", bus.blk_first, 1);
      chk("bp_last", bus.blk_last, 1);
      chk("bp_valid", bus.blk_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
    end
    bus.blk_ready = 1'b1;
    tick();
    bus.blk_ready = 1'b0;
    chk("bp_rel_valid", bus.blk_valid, 0);
    chk("bp_rel_in_ready", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
    expect_block("bp_d", put(put('0, 0, 32'h6480_0000), 15, 32'h0000_0008), 1'b1, 1'b1);

    // Reset after 7 words of a message
    send_seq(7);
    chk("mid_no_blk", bus.blk_valid, 0);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("mid_rst_valid", bus.blk_valid, 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    chk("mid_rst_first", bus.blk_first, 1);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    expect_block("mid_abc", exp_abc, 1'b1, 1'b1);

    // Reset while a full first block is waiting
    send_seq(16);
    chk("emit_valid", bus.blk_valid, 1);
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    chk("emit_rst_valid", bus.blk_valid, 0);
    chk("emit_rst_first", bus.blk_first, 1);
    chk("emit_rst_last", bus.blk_last, 0);
    send_word(32'h6162_6300, 3'd3, 1'b1);
    expect_block("emit_abc", exp_abc, 1'b1, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
